// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: funct3 codes, access sizes, FSM states.
package lsu_pkg;
  localparam int MEM_BYTES_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

  // Byte count of an access size code; code 3 is never legal so its value is irrelevant.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return 3'd1 << sz;
  endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load extension: picks byte/half/word from the raw memory word and sign/zero-extends.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_LW:   data_o = raw_i;
      F3_LBU:  data_o = {24'd0, raw_i[7:0]};
      F3_LHU:  data_o = {16'd0, raw_i[15:0]};
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request -> one memory access -> one response (IDLE/ACCESS/RESP).
// Optional ALIGN_CHECK_EN macro rejects misaligned half/word accesses.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic [1:0]        mem_access_size,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);
  lsu_state_e        state_q;
  logic              req_ready_q, resp_valid_q, resp_err_q, rw_q;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q, resp_rd_q;
  logic [31:0]       resp_rdata_q, data_in_q, load_data;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;

  logic [ADDR_W:0]   end_addr;
  logic              f3_bad, range_bad, align_bad, req_err;

  // One extra address bit so addr+bytes cannot wrap past the range check.
  always_comb begin
    f3_bad    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_is_store && req_funct3[2]);
    end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(req_funct3[1:0]));
    range_bad = end_addr > (ADDR_W+1)'(MEM_BYTES);
`ifdef ALIGN_CHECK_EN
    align_bad = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    align_bad = 1'b0;
`endif
    req_err   = f3_bad || range_bad || align_bad;
  end

  lsu_load_extend u_ext (
    .funct3_i (funct3_q),
    .raw_i    (mem_data_out),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      data_in_q    <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      rd_q         <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid && req_ready_q) begin
          req_ready_q <= 1'b0;
          is_store_q  <= req_is_store;
          funct3_q    <= req_funct3;
          rd_q        <= req_rd;
          if (req_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
          end else begin
            state_q   <= ACCESS;
            addr_q    <= req_addr;
            size_q    <= req_funct3[1:0];
            rw_q      <= req_is_store;
            data_in_q <= req_is_store ? req_wdata : 32'd0;
          end
        end
        // Store commits at the edge leaving ACCESS; load word is sampled on that same edge.
        ACCESS: begin
          state_q      <= RESP;
          rw_q         <= 1'b0;
          data_in_q    <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= is_store_q ? 32'd0 : load_data;
          resp_rd_q    <= is_store_q ? 5'd0 : rd_q;
        end
        RESP: if (resp_ready) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          rw_q         <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_err        = resp_err_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_rd         = resp_rd_q;
  assign mem_address     = addr_q;
  assign mem_read_write  = rw_q;
  assign mem_access_size = size_q;
  assign mem_data_in     = data_in_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator against a byte-array reference model.
module tb_lsu_mem_initiator;
  localparam int MB = 32;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;

  int n_cmp = 0, n_bad = 0, wr_cnt = 0;
  logic        preload;
  logic [7:0]  mem     [0:MB-1];
  logic [7:0]  ref_mem [0:MB-1];

  lsu_mem_initiator #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_access_size(mem_access_size), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Byte-addressed memory model: combinational read, write on posedge.
  always_comb begin
    mem_data_out = '0;
    for (int i = 0; i < 4; i++)
      if (longint'(mem_address) + i < MB) mem_data_out[8*i +: 8] = mem[int'(mem_address) + i];
  end

  always @(posedge clk) begin
    if (preload) begin
      {mem[3], mem[2], mem[1], mem[0]}     <= 32'h00940333;
      {mem[7], mem[6], mem[5], mem[4]}     <= 32'h413903B3;
      {mem[11], mem[10], mem[9], mem[8]}   <= 32'h035A02B3;
      for (int i = 12; i < MB; i++) mem[i] <= 8'(i * 7 + 1);
    end else if (mem_read_write) begin
      wr_cnt++;
      for (int i = 0; i < 4; i++)
        if (i < (1 << mem_access_size) && longint'(mem_address) + i < MB)
          mem[int'(mem_address) + i] <= mem_data_in[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: legality, loaded value and store side effect computed from the rules directly.
  task automatic model(input logic st, input logic [2:0] f3, input int a, input logic [31:0] wd,
                       input logic [4:0] rd, output logic e_err, output logic [31:0] e_data,
                       output logic [4:0] e_rd);
    int n;
    longint v;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3 >= 3'd4) || (a + n > MB);
`ifdef ALIGN_CHECK_EN
    if (a % n != 0) e_err = 1'b1;
`endif
    e_data = 0;
    e_rd   = 0;
    if (e_err) return;
    if (st) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
    if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    e_data = 32'(v);
    e_rd   = rd;
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input int a, input logic [31:0] wd,
                        input logic [4:0] rd, input int hold);
    logic e_err;
    logic [31:0] e_data;
    logic [4:0] e_rd;
    int w0;
    model(st, f3, a, wd, rd, e_err, e_data, e_rd);
    w0 = wr_cnt;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 1);
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    resp_ready = 0;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (e_err) begin
      chk("err_fast_valid", {31'd0, resp_valid}, 1);
    end else begin
      chk("acc_no_valid", {31'd0, resp_valid}, 0);
      chk("acc_rw", {31'd0, mem_read_write}, {31'd0, st});
      chk("acc_addr", mem_address, a);
      chk("acc_size", {30'd0, mem_access_size}, {30'd0, f3[1:0]});
      if (st) chk("acc_wdata", mem_data_in, wd);
      @(negedge clk);
    end
    for (int c = 0; c <= hold; c++) begin
      chk("resp_valid", {31'd0, resp_valid}, 1);
      chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
      chk("resp_rdata", resp_rdata, e_data);
      chk("resp_rd", {27'd0, resp_rd}, {27'd0, e_rd});
      chk("resp_req_ready", {31'd0, req_ready}, 0);
      chk("resp_rw_low", {31'd0, mem_read_write}, 0);
      if (c < hold) @(negedge clk);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("post_valid", {31'd0, resp_valid}, 0);
    chk("post_ready", {31'd0, req_ready}, 1);
    chk("write_count", wr_cnt - w0, (st && !e_err) ? 1 : 0);
  endtask

  initial begin
    logic [2:0] f3;
    int w0;
    rst_n = 0; preload = 1;
    req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    resp_ready = 0;
    {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]}   = 32'h00940333;
    {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}   = 32'h413903B3;
    {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]} = 32'h035A02B3;
    for (int i = 12; i < MB; i++) ref_mem[i] = 8'(i * 7 + 1);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_rd", {27'd0, resp_rd}, 0);
    chk("rst_err", {31'd0, resp_err}, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_rw", {31'd0, mem_read_write}, 0);
    chk("rst_mem_size", {30'd0, mem_access_size}, 0);
    chk("rst_mem_din", mem_data_in, 0);
    rst_n = 1; preload = 0;

    // Directed cases from the preloaded image.
    do_req(0, 3'b000, 2, 0, 5'd3, 0);            // LB 0x94
    do_req(0, 3'b100, 2, 0, 5'd4, 0);            // LBU
    do_req(0, 3'b000, 4, 0, 5'd5, 1);            // LB 0xB3
    do_req(0, 3'b001, 6, 0, 5'd6, 0);            // LH 0x4139
    do_req(0, 3'b101, 4, 0, 5'd7, 0);            // LHU 0x03B3
    do_req(0, 3'b010, 0, 0, 5'd31, 0);           // LW
    do_req(1, 3'b000, 8, 32'h000000AB, 5'd9, 0); // SB
    do_req(0, 3'b010, 8, 0, 5'd10, 0);           // LW 0x035A02AB
    do_req(0, 3'b010, 29, 0, 5'd11, 0);          // out of range
    do_req(0, 3'b011, 0, 0, 5'd12, 0);           // illegal funct3
    do_req(1, 3'b100, 0, 32'h1, 5'd1, 0);        // load-only funct3 on a store
    do_req(0, 3'b000, 31, 0, 5'd13, 0);          // last byte legal
    do_req(0, 3'b001, 31, 0, 5'd14, 0);          // half at last byte: error
    do_req(0, 3'b010, 28, 0, 5'd15, 0);          // last word legal
    do_req(0, 3'b010, 4, 0, 5'd16, 5);           // consumer stalls

    // Reset during the ACCESS cycle of SW addr12 must suppress the write.
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1; req_is_store = 1; req_funct3 = 3'b010; req_addr = 12; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 0;
    chk("rstmid_in_access", {31'd0, mem_read_write}, 1);
    rst_n = 0;
    #1;
    chk("rstmid_valid", {31'd0, resp_valid}, 0);
    chk("rstmid_ready", {31'd0, req_ready}, 1);
    chk("rstmid_rw", {31'd0, mem_read_write}, 0);
    @(negedge clk);
    rst_n = 1;
    chk("rstmid_word12", {mem[15], mem[14], mem[13], mem[12]},
        {ref_mem[15], ref_mem[14], ref_mem[13], ref_mem[12]});
    chk("rstmid_wrcnt", wr_cnt - w0, 0);
    do_req(0, 3'b001, 1, 0, 5'd17, 0);           // misaligned half

    for (int t = 0; t < 60; t++) begin
      f3 = 3'($urandom_range(0, 7));
      do_req(1'($urandom), f3, $urandom_range(0, 35), $urandom, 5'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    for (int i = 0; i < MB; i += 4)
      chk("final_mem", {mem[i+3], mem[i+2], mem[i+1], mem[i]},
          {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
